state_level_bank: RTL and testbench
===================================

# state_level_bank

Parametrised bank of per-channel level registers, each a bounded up/down counter selected by address. Each entry holds either an inactive marker (0) or an active level in [MIN_LVL, MAX_LVL]. It replaces the fixed 8×3 state register. Over that block it adds configurable bounds and presets, a direct write port, boundary flags, a registered clear-event pulse, and optional wrap-around. It sits between the button/command decoder (UpState/DownState/WrEn) and the display/driver FSMs that read stateValue.

## Interface
- BIT_ADDR, 3, address width; NREG = 2**BIT_ADDR entries
- BIT_DATO, 3, entry width
- MIN_LVL, 1, lowest active level; must be ≥1
- MAX_LVL, 5, highest active level; must be > MIN_LVL and < 2**BIT_DATO
- RST_LVL, 5, reset value of entries 0..RST_ACTIVE_CNT-1; must lie in [MIN_LVL, MAX_LVL]
- RST_ACTIVE_CNT, 5, number of entries preset active on reset; the remaining entries reset to 0
- KILL_ADDR, 4, entry whose arrival at MIN_LVL clears the whole bank
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- state  in  BIT_ADDR  selected entry for read, step, and write
- UpState  in  1  increment request for the selected entry
- DownState  in  1  decrement request for the selected entry
- WrEn  in  1  direct write of WrData into the selected entry
- WrData  in  BIT_DATO  write data, stored unmodified; 0 is legal and deactivates the entry
- stateValue  out  BIT_DATO  combinational read of breg[state]
- AtMax  out  1  combinational; selected entry == MAX_LVL
- AtMin  out  1  combinational; selected entry == MIN_LVL
- ClrPulse  out  1  registered; one-cycle pulse after a bank clear

## Operation
- Priority at each rising edge, highest first: rst > bank clear > WrEn > step.
- rst: entries 0..RST_ACTIVE_CNT-1 ← RST_LVL; all other entries ← 0; ClrPulse ← 0.
- Bank clear: when the registered breg[KILL_ADDR] == MIN_LVL, all entries ← 0 and ClrPulse ← 1. WrEn, UpState, and DownState are ignored on that edge.
- Write: breg[state] ← WrData. UpState and DownState are ignored on that edge.
- Step applies only when the selected entry is in [MIN_LVL, MAX_LVL]. Entries holding 0 or any other out-of-range value never step.
- UpState alone: +1 if the entry is below MAX_LVL. At MAX_LVL, see Configuration.
- DownState alone: −1 if the entry is above MIN_LVL. At MIN_LVL, see Configuration.
- UpState and DownState together: no change.
- Arithmetic is BIT_DATO wide. The bounds guarantee the result never overflows or underflows.
- Only the addressed entry changes on a write or step.

## Timing
- Read path (stateValue, AtMax, AtMin) is combinational from registers and state. There are no read-during-write bypasses: the new value is visible the cycle after the edge.
- Clear has one edge of latency. An edge that moves KILL_ADDR to MIN_LVL is followed at the next edge by a bank clear. ClrPulse is high for exactly the cycle after the clear edge.
- A clear does not retrigger, because KILL_ADDR becomes 0 after clearing.
- A write of MIN_LVL into KILL_ADDR also triggers a clear on the following edge.
- rst asserted mid-operation overrides everything on that edge, including a pending clear. ClrPulse is 0 the cycle after rst.
- Reset values of outputs after rst with state=0: stateValue=RST_LVL, AtMax=(RST_LVL==MAX_LVL), AtMin=(RST_LVL==MIN_LVL), ClrPulse=0.
- The $readmemh preload file is no longer used. Contents are undefined until the first rst.

## Configuration
- STATE_BANK_WRAP_EN defined: an up step at MAX_LVL wraps to MIN_LVL, and a down step at MIN_LVL wraps to MAX_LVL.
- STATE_BANK_WRAP_EN undefined: levels saturate; an up step at MAX_LVL and a down step at MIN_LVL cause no change.
- Wrap never produces 0 and never steps an inactive entry.

## Test plan
- Default parameters, rst for 1 cycle → read state 0..7 gives 5,5,5,5,5,0,0,0; ClrPulse=0.
- state=2, DownState for 4 edges → value 1 and AtMin=1. A 5th edge gives 1 (saturate), or 5 with STATE_BANK_WRAP_EN.
- state=6 (value 0), UpState for 3 edges → value stays 0; AtMax=AtMin=0.
- state=4, DownState for 4 edges → value 1. The next edge clears all 8 entries to 0. ClrPulse=1 for one cycle. An UpState presented on the clear edge is ignored.
- state=6, WrEn with WrData=3 → 3. Then UpState and DownState together → 3. Then WrEn and UpState together with WrData=2 → 2.
- rst asserted with UpState=1 on state=0 while KILL_ADDR==1 → presets restored (5,5,5,5,5,0,0,0), no clear, ClrPulse=0.

Source files
------------

// File: rtl/state_level_bank.sv
// Bank of per-channel bounded up/down level registers with direct write, boundary flags
// and a clear-on-kill-entry event. Optional wrap-around: define STATE_BANK_WRAP_EN.
module state_level_bank #(
  parameter int BIT_ADDR       = 3,
  parameter int BIT_DATO       = 3,
  parameter int MIN_LVL        = 1,
  parameter int MAX_LVL        = 5,
  parameter int RST_LVL        = 5,
  parameter int RST_ACTIVE_CNT = 5,
  parameter int KILL_ADDR      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] state,
  input  logic                UpState,
  input  logic                DownState,
  input  logic                WrEn,
  input  logic [BIT_DATO-1:0] WrData,
  output logic [BIT_DATO-1:0] stateValue,
  output logic                AtMax,
  output logic                AtMin,
  output logic                ClrPulse
);

  localparam int                  NREG   = 2 ** BIT_ADDR;
  localparam logic [BIT_DATO-1:0] L_MIN  = BIT_DATO'(MIN_LVL);
  localparam logic [BIT_DATO-1:0] L_MAX  = BIT_DATO'(MAX_LVL);
  localparam logic [BIT_DATO-1:0] L_RST  = BIT_DATO'(RST_LVL);
  localparam logic [BIT_DATO-1:0] L_ONE  = BIT_DATO'(1);
  localparam logic [BIT_ADDR-1:0] L_KILL = BIT_ADDR'(KILL_ADDR);

  logic [BIT_DATO-1:0] r_breg [NREG];
  logic                r_clr_pulse;

  logic [BIT_DATO-1:0] w_sel;
  logic                w_active;
  logic                w_kill;
  logic [BIT_DATO-1:0] w_step_val;

  assign w_sel    = r_breg[state];
  assign w_active = (w_sel >= L_MIN) && (w_sel <= L_MAX);
  assign w_kill   = (r_breg[L_KILL] == L_MIN);

  always_comb begin
    // NOTE: default first so every path assigns w_step_val; otherwise a latch is inferred.
    w_step_val = w_sel;
    if (w_active && (UpState != DownState)) begin
      if (UpState) begin
        if (w_sel < L_MAX) w_step_val = w_sel + L_ONE;
`ifdef STATE_BANK_WRAP_EN
        else               w_step_val = L_MIN;
`else
        else               w_step_val = w_sel;
`endif
      end else begin
        if (w_sel > L_MIN) w_step_val = w_sel - L_ONE;
`ifdef STATE_BANK_WRAP_EN
        else               w_step_val = L_MAX;
`else
        else               w_step_val = w_sel;
`endif
      end
    end
  end

  // Priority: rst > bank clear > write > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is small and its preset is functional, so every entry is reset
      // explicitly rather than left to a preload.
      for (int i = 0; i < NREG; i++)
        r_breg[i] <= (i < RST_ACTIVE_CNT) ? L_RST : '0;
      r_clr_pulse <= 1'b0;
    end else if (w_kill) begin
      for (int i = 0; i < NREG; i++)
        r_breg[i] <= '0;
      r_clr_pulse <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      r_clr_pulse <= 1'b0;
      if (WrEn) r_breg[state] <= WrData;
      else      r_breg[state] <= w_step_val;
    end
  end

  assign stateValue = w_sel;
  assign AtMax      = (w_sel == L_MAX);
  assign AtMin      = (w_sel == L_MIN);
  assign ClrPulse   = r_clr_pulse;

endmodule

// File: tb/tb_state_level_bank.sv
// Self-checking bench for state_level_bank: directed plan steps, then random traffic
// compared against a level-rule reference model.
`timescale 1ns/1ps
module tb_state_level_bank;

  localparam int NREG = 8;
  localparam int MINL = 1;
  localparam int MAXL = 5;
  localparam int RSTL = 5;
  localparam int RCNT = 5;
  localparam int KILL = 4;
`ifdef STATE_BANK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state = '0;
  logic       UpState = 1'b0;
  logic       DownState = 1'b0;
  logic       WrEn = 1'b0;
  logic [2:0] WrData = '0;
  logic [2:0] stateValue;
  logic       AtMax;
  logic       AtMin;
  logic       ClrPulse;

  int total = 0;
  int bad   = 0;

  int m [NREG];
  int m_pulse = 0;

  state_level_bank #(
    .BIT_ADDR(3), .BIT_DATO(3), .MIN_LVL(MINL), .MAX_LVL(MAXL),
    .RST_LVL(RSTL), .RST_ACTIVE_CNT(RCNT), .KILL_ADDR(KILL)
  ) dut (
    .clk(clk), .rst(rst), .state(state), .UpState(UpState), .DownState(DownState),
    .WrEn(WrEn), .WrData(WrData), .stateValue(stateValue), .AtMax(AtMax),
    .AtMin(AtMin), .ClrPulse(ClrPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one clock edge applied to the model from the level rules.
  task automatic model_edge(input int st, input bit up, input bit dn, input bit wr,
                            input int wd, input bit r);
    if (r) begin
      for (int i = 0; i < NREG; i++) m[i] = (i < RCNT) ? RSTL : 0;
      m_pulse = 0;
    end else if (m[KILL] == MINL) begin
      for (int i = 0; i < NREG; i++) m[i] = 0;
      m_pulse = 1;
    end else begin
      m_pulse = 0;
      if (wr) m[st] = wd;
      else if (m[st] >= MINL && m[st] <= MAXL && up != dn) begin
        if (up) m[st] = (m[st] < MAXL) ? m[st] + 1 : (WRAP ? MINL : m[st]);
        else    m[st] = (m[st] > MINL) ? m[st] - 1 : (WRAP ? MAXL : m[st]);
      end
    end
  endtask

  task automatic check_sel(input string tag);
    int v;
    v = m[state];
    check({tag, ".val"},   32'(stateValue), 32'(v));
    check({tag, ".max"},   32'(AtMax),      32'(v == MAXL));
    check({tag, ".min"},   32'(AtMin),      32'(v == MINL));
    check({tag, ".pulse"}, 32'(ClrPulse),   32'(m_pulse));
  endtask

  // Drive one edge's inputs, advance, update model, check selected entry.
  task automatic step(input string tag, input int st, input bit up, input bit dn,
                      input bit wr, input int wd, input bit r);
    state = 3'(st); UpState = up; DownState = dn; WrEn = wr; WrData = 3'(wd); rst = r;
    @(posedge clk);
    model_edge(st, up, dn, wr, wd, r);
    #1;
    rst = 1'b0; UpState = 1'b0; DownState = 1'b0; WrEn = 1'b0;
    check_sel(tag);
  endtask

  // Combinational read of every entry within one clock period.
  task automatic sweep(input string tag, input int exp_vals [NREG]);
    for (int i = 0; i < NREG; i++) begin
      state = 3'(i);
      #0.9;
      check($sformatf("%s[%0d]", tag, i), 32'(stateValue), 32'(exp_vals[i]));
    end
  endtask

  int presets [NREG] = '{5, 5, 5, 5, 5, 0, 0, 0};
  int zeros   [NREG] = '{0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    // Reset and preset readback.
    step("rst", 0, 0, 0, 0, 0, 1);
    sweep("preset", presets);

    // Step down to MIN, then one more edge at MIN.
    for (int k = 0; k < 4; k++) step("dn2", 2, 0, 1, 0, 0, 0);
    check("dn2.lit", 32'(stateValue), 32'(1));
    check("dn2.atmin", 32'(AtMin), 32'(1));
    step("dn2.edge", 2, 0, 1, 0, 0, 0);
    check("dn2.edge.lit", 32'(stateValue), WRAP ? 32'(5) : 32'(1));

    // Inactive entry never steps.
    for (int k = 0; k < 3; k++) step("up6", 6, 1, 0, 0, 0, 0);
    check("up6.lit", 32'(stateValue), 32'(0));

    // Kill entry to MIN, then clear edge with an UpState that must be ignored.
    for (int k = 0; k < 4; k++) step("dn4", 4, 0, 1, 0, 0, 0);
    check("dn4.lit", 32'(stateValue), 32'(1));
    step("clear", 4, 1, 0, 0, 0, 0);
    check("clear.pulse.lit", 32'(ClrPulse), 32'(1));
    sweep("cleared", zeros);
    step("after_clear", 4, 0, 0, 0, 0, 0);
    check("after_clear.pulse.lit", 32'(ClrPulse), 32'(0));

    // Write, simultaneous up/down, write beating up.
    step("wr6", 6, 0, 0, 1, 3, 0);
    check("wr6.lit", 32'(stateValue), 32'(3));
    step("updn6", 6, 1, 1, 0, 0, 0);
    check("updn6.lit", 32'(stateValue), 32'(3));
    step("wrup6", 6, 1, 0, 1, 2, 0);
    check("wrup6.lit", 32'(stateValue), 32'(2));

    // Arm a clear via write, then rst on the pending-clear edge.
    step("rst_arm", 4, 0, 0, 0, 0, 1);
    step("wrkill", 4, 0, 0, 1, 1, 0);
    step("rst_over", 0, 1, 0, 0, 0, 1);
    check("rst_over.pulse.lit", 32'(ClrPulse), 32'(0));
    sweep("rst_over", presets);
    step("rst_over.next", 0, 0, 0, 0, 0, 0);
    check("rst_over.next.pulse.lit", 32'(ClrPulse), 32'(0));

    // Up to MAX and past it.
    step("up0", 0, 1, 0, 0, 0, 0);
    check("up0.lit", 32'(stateValue), WRAP ? 32'(1) : 32'(5));

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int st, wd;
      bit up, dn, wr, r;
      st = int'($urandom_range(0, NREG - 1));
      wd = int'($urandom_range(0, 7));
      up = 1'($urandom);
      dn = 1'($urandom);
      wr = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 60) == 0);
      step("rand", st, up, dn, wr, wd, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
